// File: rtl/frame_buffer_writer_pkg.sv
// Shared constants and state type for the frame-buffer write path.
package frame_buffer_writer_pkg;

  // Default frame geometry; must match the display-side read logic.
  localparam int DISPLAY_WIDTH  = 320;
  localparam int DISPLAY_HEIGHT = 240;
  localparam int ADDR_BITS      = 17;

  // Write-controller states.
  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_SWAP = 2'd1,
    SWAP      = 2'd2
  } fbw_state_e;

endpackage

// File: rtl/frame_buffer_writer_pixel_addr_gen.sv
// Coordinate-to-linear-address stage. Registers y*WIDTH+x and the range
// check so the result lines up with the write strobe one cycle later.
module pixel_addr_gen #(
  parameter int WIDTH     = 320,
  parameter int HEIGHT    = 240,
  parameter int ADDR_BITS = 17,
  parameter int X_BITS    = 9,
  parameter int Y_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [X_BITS-1:0]    x_in,
  input  logic [Y_BITS-1:0]    y_in,
  output logic                 in_range_now_out,
  output logic                 valid_out,
  output logic                 in_range_out,
  output logic [ADDR_BITS-1:0] addr_out
);
  import frame_buffer_writer_pkg::*;

  // Wide enough that neither the compare nor the product can overflow.
  localparam int FULL_BITS = X_BITS + Y_BITS + 32;

  logic [FULL_BITS-1:0] lin_full;
  logic                 in_range;
  logic                 valid_q, valid_d;
  logic                 in_range_q, in_range_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;

  // Range check and full-width linear address, then next-state for the stage.
  always_comb begin
    in_range = (FULL_BITS'(x_in) < FULL_BITS'(WIDTH)) &&
               (FULL_BITS'(y_in) < FULL_BITS'(HEIGHT));
    lin_full = FULL_BITS'(y_in) * FULL_BITS'(WIDTH) + FULL_BITS'(x_in);
    valid_d    = valid_in;
    in_range_d = valid_in ? in_range : in_range_q;
    // Hold the last address when idle so the bus does not toggle needlessly.
    addr_d     = valid_in ? lin_full[ADDR_BITS-1:0] : addr_q;
  end

  // Pipeline register: this is the one-cycle write latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      in_range_q <= 1'b0;
      addr_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      in_range_q <= in_range_d;
      addr_q     <= addr_d;
    end
  end

  assign in_range_now_out = in_range;
  assign valid_out        = valid_q;
  assign in_range_out     = in_range_q;
  assign addr_out         = addr_q;

endmodule

// File: rtl/frame_buffer_writer.sv
// Double-buffered frame-buffer write controller. Pixels go to the back bank;
// banks swap on the first vsync rising edge after a complete frame.
module frame_buffer_writer #(
  parameter int WIDTH     = frame_buffer_writer_pkg::DISPLAY_WIDTH,
  parameter int HEIGHT    = frame_buffer_writer_pkg::DISPLAY_HEIGHT,
  parameter int ADDR_BITS = frame_buffer_writer_pkg::ADDR_BITS,
  parameter int X_BITS    = 9,
  parameter int Y_BITS    = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 pixel_valid_in,
  output logic                 pixel_ready_out,
  input  logic [X_BITS-1:0]    pixel_x_in,
  input  logic [Y_BITS-1:0]    pixel_y_in,
  input  logic [3:0]           pixel_data_in,
  input  logic                 vsync_in,
  output logic                 wr_en_out,
  output logic [ADDR_BITS:0]   wr_addr_out,
  output logic [3:0]           wr_data_out,
  output logic                 display_bank_out,
  output logic                 frame_done_out,
  output logic                 coord_err_out
);
  import frame_buffer_writer_pkg::*;

  // One extra bit so a full frame's pixel count is representable.
  localparam int CW = ADDR_BITS + 1;
  localparam logic [CW-1:0] FRAME_PIXELS = CW'(WIDTH * HEIGHT);

  fbw_state_e           state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 display_bank_q, display_bank_d;
  logic                 frame_done_q, frame_done_d;
  logic                 coord_err_q, coord_err_d;
  logic                 vsync_q, vsync_d;
  logic [3:0]           wr_data_q, wr_data_d;
  logic                 wr_bank_q, wr_bank_d;

  logic                 accept;
  logic                 vsync_edge;
  logic                 in_range_now;
  logic                 wr_valid;
  logic                 wr_in_range;
  logic [ADDR_BITS-1:0] wr_lin_addr;

  // Ready comes from registered state only, so it never depends on valid.
  assign pixel_ready_out = (state_q == FILL);
  assign accept          = pixel_valid_in && pixel_ready_out;
  assign vsync_edge      = vsync_in && !vsync_q;

  pixel_addr_gen #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .ADDR_BITS (ADDR_BITS),
    .X_BITS    (X_BITS),
    .Y_BITS    (Y_BITS)
  ) u_addr_gen (
    .clk              (clk_in),
    .rst              (rst_in),
    .valid_in         (accept),
    .x_in             (pixel_x_in),
    .y_in             (pixel_y_in),
    .in_range_now_out (in_range_now),
    .valid_out        (wr_valid),
    .in_range_out     (wr_in_range),
    .addr_out         (wr_lin_addr)
  );

  // Next-state logic: pixel counting, frame completion and bank swap.
  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    display_bank_d = display_bank_q;
    frame_done_d   = 1'b0;
    coord_err_d    = coord_err_q;
    vsync_d        = vsync_in;
    wr_data_d      = wr_data_q;
    wr_bank_d      = wr_bank_q;

    // Capture data and the current back bank alongside the address stage, so
    // the final pixel always lands in the bank it was rendered for.
    if (accept) begin
      wr_data_d = pixel_data_in;
      wr_bank_d = ~display_bank_q;
    end

    case (state_q)
      FILL: begin
        if (accept) begin
          if (in_range_now) begin
            count_d = count_q + CW'(1);
            if (count_d == FRAME_PIXELS) state_d = WAIT_SWAP;
          end else begin
            coord_err_d = 1'b1;
          end
        end
      end
      WAIT_SWAP: begin
        // Toggle on the way into SWAP so the new bank and the done pulse are
        // visible during the SWAP cycle itself.
        if (vsync_edge) begin
          state_d        = SWAP;
          display_bank_d = ~display_bank_q;
          frame_done_d   = 1'b1;
        end
      end
      SWAP: begin
        count_d = '0;
        state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q        <= FILL;
      count_q        <= '0;
      display_bank_q <= 1'b0;
      frame_done_q   <= 1'b0;
      coord_err_q    <= 1'b0;
      vsync_q        <= 1'b0;
      wr_data_q      <= '0;
      wr_bank_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      display_bank_q <= display_bank_d;
      frame_done_q   <= frame_done_d;
      coord_err_q    <= coord_err_d;
      vsync_q        <= vsync_d;
      wr_data_q      <= wr_data_d;
      wr_bank_q      <= wr_bank_d;
    end
  end

  assign wr_en_out        = wr_valid && wr_in_range;
  assign wr_addr_out      = {wr_bank_q, wr_lin_addr};
  assign wr_data_out      = wr_data_q;
  assign display_bank_out = display_bank_q;
  assign frame_done_out   = frame_done_q;
  assign coord_err_out    = coord_err_q;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer on a 4x2 frame.
module tb_frame_buffer_writer;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AB = 3;
  localparam int XB = 3;
  localparam int YB = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pixel_valid_in = 1'b0;
  logic          pixel_ready_out;
  logic [XB-1:0] pixel_x_in = '0;
  logic [YB-1:0] pixel_y_in = '0;
  logic [3:0]    pixel_data_in = '0;
  logic          vsync_in = 1'b0;
  logic          wr_en_out;
  logic [AB:0]   wr_addr_out;
  logic [3:0]    wr_data_out;
  logic          display_bank_out;
  logic          frame_done_out;
  logic          coord_err_out;

  int n_cmp = 0;
  int n_bad = 0;

  frame_buffer_writer #(
    .WIDTH(W), .HEIGHT(H), .ADDR_BITS(AB), .X_BITS(XB), .Y_BITS(YB)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .pixel_valid_in   (pixel_valid_in),
    .pixel_ready_out  (pixel_ready_out),
    .pixel_x_in       (pixel_x_in),
    .pixel_y_in       (pixel_y_in),
    .pixel_data_in    (pixel_data_in),
    .vsync_in         (vsync_in),
    .wr_en_out        (wr_en_out),
    .wr_addr_out      (wr_addr_out),
    .wr_data_out      (wr_data_out),
    .display_bank_out (display_bank_out),
    .frame_done_out   (frame_done_out),
    .coord_err_out    (coord_err_out)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one pixel for exactly one cycle (accepted when ready is high).
  task automatic push(input int x, input int y, input int d);
    pixel_valid_in = 1'b1;
    pixel_x_in     = XB'(x);
    pixel_y_in     = YB'(y);
    pixel_data_in  = 4'(d);
    tick();
    pixel_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    vsync_in = 1'b0;
    pixel_valid_in = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (wr_en_out !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b want 0", wr_en_out); end
    n_cmp++; if (wr_addr_out !== 4'd0) begin n_bad++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr_out); end
    n_cmp++; if (display_bank_out !== 1'b0) begin n_bad++; $display("FAIL reset_bank got %b want 0", display_bank_out); end
    n_cmp++; if (pixel_ready_out !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", pixel_ready_out); end
    n_cmp++; if ({frame_done_out, coord_err_out} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got %b want 00", {frame_done_out, coord_err_out}); end
    $display("test_reset done");
  endtask

  // Full raster frame into bank 1 (addresses 8..15), then a vsync swap.
  task automatic test_raster_and_swap();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      push(k % W, k / W, k);
      $display("pixel k=%0d wr_en=%b addr=%0d data=%0d ready=%b", k, wr_en_out, wr_addr_out, wr_data_out, pixel_ready_out);
      n_cmp++; if (wr_en_out !== 1'b1) begin n_bad++; $display("FAIL raster_wr_en k=%0d got %b want 1", k, wr_en_out); end
      n_cmp++; if (wr_addr_out !== 4'(8 + k)) begin n_bad++; $display("FAIL raster_addr k=%0d got %0d want %0d", k, wr_addr_out, 8 + k); end
      n_cmp++; if (wr_data_out !== 4'(k)) begin n_bad++; $display("FAIL raster_data k=%0d got %0d want %0d", k, wr_data_out, k); end
      n_cmp++; if (pixel_ready_out !== (k < 7)) begin n_bad++; $display("FAIL raster_ready k=%0d got %b want %b", k, pixel_ready_out, k < 7); end
    end
    tick();
    n_cmp++; if (wr_en_out !== 1'b0) begin n_bad++; $display("FAIL raster_idle_wr_en got %b want 0", wr_en_out); end
    n_cmp++; if (display_bank_out !== 1'b0) begin n_bad++; $display("FAIL raster_bank_wait got %b want 0", display_bank_out); end
    vsync_in = 1'b1;
    tick();
    $display("swap bank=%b frame_done=%b ready=%b", display_bank_out, frame_done_out, pixel_ready_out);
    n_cmp++; if (display_bank_out !== 1'b1) begin n_bad++; $display("FAIL swap_bank got %b want 1", display_bank_out); end
    n_cmp++; if (frame_done_out !== 1'b1) begin n_bad++; $display("FAIL swap_done got %b want 1", frame_done_out); end
    n_cmp++; if (pixel_ready_out !== 1'b0) begin n_bad++; $display("FAIL swap_ready got %b want 0", pixel_ready_out); end
    tick();
    n_cmp++; if (frame_done_out !== 1'b0) begin n_bad++; $display("FAIL swap_done_pulse got %b want 0", frame_done_out); end
    n_cmp++; if (pixel_ready_out !== 1'b1) begin n_bad++; $display("FAIL swap_ready_back got %b want 1", pixel_ready_out); end
    vsync_in = 1'b0;
    push(0, 0, 5);
    $display("next frame pixel (0,0) wr_en=%b addr=%0d data=%0d", wr_en_out, wr_addr_out, wr_data_out);
    n_cmp++; if (wr_en_out !== 1'b1 || wr_addr_out !== 4'd0 || wr_data_out !== 4'd5) begin n_bad++; $display("FAIL swap_next_write got en=%b addr=%0d data=%0d want en=1 addr=0 data=5", wr_en_out, wr_addr_out, wr_data_out); end
  endtask

  // A vsync edge while filling must not swap.
  task automatic test_early_vsync();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      vsync_in = (k == 3);
      push(k % W, k / W, 15 - k);
      $display("pixel k=%0d vsync=%b bank=%b done=%b", k, vsync_in, display_bank_out, frame_done_out);
      n_cmp++; if (display_bank_out !== 1'b0 || frame_done_out !== 1'b0) begin n_bad++; $display("FAIL early_vsync k=%0d got bank=%b done=%b want 0 0", k, display_bank_out, frame_done_out); end
    end
    vsync_in = 1'b0;
    tick();
    vsync_in = 1'b1;
    tick();
    n_cmp++; if (display_bank_out !== 1'b1 || frame_done_out !== 1'b1) begin n_bad++; $display("FAIL early_vsync_swap got bank=%b done=%b want 1 1", display_bank_out, frame_done_out); end
    vsync_in = 1'b0;
    tick();
  endtask

  // Out-of-range pixels are dropped, flagged stickily, and do not count.
  task automatic test_out_of_range();
    do_reset();
    push(4, 0, 9);
    $display("oob (4,0) wr_en=%b err=%b", wr_en_out, coord_err_out);
    n_cmp++; if (wr_en_out !== 1'b0) begin n_bad++; $display("FAIL oob_wr_en got %b want 0", wr_en_out); end
    n_cmp++; if (coord_err_out !== 1'b1) begin n_bad++; $display("FAIL oob_err got %b want 1", coord_err_out); end
    push(0, 2, 9);
    n_cmp++; if (wr_en_out !== 1'b0) begin n_bad++; $display("FAIL oob_y_wr_en got %b want 0", wr_en_out); end
    for (int k = 0; k < 8; k++) begin
      push(k % W, k / W, k);
      n_cmp++; if (pixel_ready_out !== (k < 7)) begin n_bad++; $display("FAIL oob_count k=%0d ready got %b want %b", k, pixel_ready_out, k < 7); end
    end
    tick();
    n_cmp++; if (coord_err_out !== 1'b1) begin n_bad++; $display("FAIL oob_err_sticky got %b want 1", coord_err_out); end
  endtask

  // Last pixel and vsync edge on the same cycle: that edge is ignored.
  task automatic test_same_cycle_edge();
    do_reset();
    for (int k = 0; k < 7; k++) push(k % W, k / W, k);
    vsync_in = 1'b1;
    push(3, 1, 7);
    n_cmp++; if (pixel_ready_out !== 1'b0 || display_bank_out !== 1'b0 || frame_done_out !== 1'b0) begin n_bad++; $display("FAIL same_edge_first got ready=%b bank=%b done=%b want 0 0 0", pixel_ready_out, display_bank_out, frame_done_out); end
    tick();
    n_cmp++; if (display_bank_out !== 1'b0) begin n_bad++; $display("FAIL same_edge_hold got bank=%b want 0", display_bank_out); end
    vsync_in = 1'b0;
    tick();
    vsync_in = 1'b1;
    tick();
    $display("same-cycle edge: second edge bank=%b done=%b", display_bank_out, frame_done_out);
    n_cmp++; if (display_bank_out !== 1'b1 || frame_done_out !== 1'b1) begin n_bad++; $display("FAIL same_edge_swap got bank=%b done=%b want 1 1", display_bank_out, frame_done_out); end
    vsync_in = 1'b0;
    tick();
  endtask

  // Asynchronous reset mid-frame clears outputs without a clock edge.
  task automatic test_async_reset();
    do_reset();
    push(0, 0, 1);
    push(4, 1, 2);
    for (int k = 1; k < 5; k++) push(k % W, k / W, k);
    #2;
    rst = 1'b1;
    #1;
    $display("async reset wr_en=%b addr=%0d data=%0d err=%b", wr_en_out, wr_addr_out, wr_data_out, coord_err_out);
    n_cmp++; if (wr_en_out !== 1'b0 || wr_addr_out !== 4'd0 || wr_data_out !== 4'd0) begin n_bad++; $display("FAIL async_wr got en=%b addr=%0d data=%0d want 0 0 0", wr_en_out, wr_addr_out, wr_data_out); end
    n_cmp++; if (coord_err_out !== 1'b0 || display_bank_out !== 1'b0 || pixel_ready_out !== 1'b1) begin n_bad++; $display("FAIL async_state got err=%b bank=%b ready=%b want 0 0 1", coord_err_out, display_bank_out, pixel_ready_out); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 7; k++) push(k % W, k / W, k);
    n_cmp++; if (pixel_ready_out !== 1'b1) begin n_bad++; $display("FAIL async_fresh_count got ready=%b want 1", pixel_ready_out); end
    push(3, 1, 7);
    n_cmp++; if (pixel_ready_out !== 1'b0 || wr_addr_out !== 4'd15) begin n_bad++; $display("FAIL async_last got ready=%b addr=%0d want 0 15", pixel_ready_out, wr_addr_out); end
    vsync_in = 1'b1;
    tick();
    n_cmp++; if (display_bank_out !== 1'b1) begin n_bad++; $display("FAIL async_swap got bank=%b want 1", display_bank_out); end
    vsync_in = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_raster_and_swap();
    test_early_vsync();
    test_out_of_range();
    test_same_cycle_edge();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
